// File: rtl/mem.sv
// True dual-port, single-clock, read-first RAM with synchronous clear of all words.
// Define MEM_COLLISION_CHECK_EN to get a simulation error on same-address dual writes.
module mem #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] in_data_a,
  input  logic [ADDR_WIDTH-1:0] in_addr_a,
  input  logic                  en_a,
  input  logic                  we_a,
  output logic [DATA_WIDTH-1:0] out_data_a,
  input  logic [DATA_WIDTH-1:0] in_data_b,
  input  logic [ADDR_WIDTH-1:0] in_addr_b,
  input  logic                  en_b,
  input  logic                  we_b,
  output logic [DATA_WIDTH-1:0] out_data_b
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] memory [DEPTH];
  logic [DATA_WIDTH-1:0] out_data_a_q;
  logic [DATA_WIDTH-1:0] out_data_b_q;

  // Reads sample the pre-edge array, so both ports see old data (read-first).
  // Port B's write is scheduled after port A's, so B wins a same-address collision.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        memory[i] <= '0;
      end
      out_data_a_q <= '0;
      out_data_b_q <= '0;
    end else begin
      if (en_a) begin
        out_data_a_q <= memory[in_addr_a];
        if (we_a) begin
          memory[in_addr_a] <= in_data_a;
        end
      end
      if (en_b) begin
        out_data_b_q <= memory[in_addr_b];
        if (we_b) begin
          memory[in_addr_b] <= in_data_b;
        end
      end
    end
  end

  assign out_data_a = out_data_a_q;
  assign out_data_b = out_data_b_q;

`ifdef MEM_COLLISION_CHECK_EN
  always_ff @(posedge clk) begin
    if (!rst && en_a && we_a && en_b && we_b && (in_addr_a == in_addr_b)) begin
      $error("mem: write collision addr_a=%h addr_b=%h time=%0t", in_addr_a, in_addr_b, $time);
    end
  end
`endif

endmodule

// File: tb/tb_mem.sv
// Directed plus random stimulus for mem, checked against a behavioural array model.
module tb_mem;

  logic       clk;
  logic       rst;
  logic [7:0] in_data_a, in_addr_a, in_data_b, in_addr_b;
  logic       en_a, we_a, en_b, we_b;
  logic [7:0] out_data_a, out_data_b;

  logic [7:0] model [256];
  logic [7:0] exp_out_a, exp_out_b;
  logic [7:0] exp_a_q[$];
  logic [7:0] exp_b_q[$];
  int         compared;
  int         mismatched;

  mem #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) dut (
    .clk(clk), .rst(rst),
    .in_data_a(in_data_a), .in_addr_a(in_addr_a), .en_a(en_a), .we_a(we_a), .out_data_a(out_data_a),
    .in_data_b(in_data_b), .in_addr_b(in_addr_b), .en_b(en_b), .we_b(we_b), .out_data_b(out_data_b)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Driver tasks
  task automatic set_a(input logic en, input logic we, input logic [7:0] addr, input logic [7:0] data);
    en_a = en; we_a = we; in_addr_a = addr; in_data_a = data;
  endtask

  task automatic set_b(input logic en, input logic we, input logic [7:0] addr, input logic [7:0] data);
    en_b = en; we_b = we; in_addr_b = addr; in_data_b = data;
  endtask

  task automatic idle();
    set_a(1'b0, 1'b0, 8'h00, 8'h00);
    set_b(1'b0, 1'b0, 8'h00, 8'h00);
  endtask

  // Predict this edge from the model, clock it, then compare both outputs.
  task automatic step(input string tag);
    logic [7:0] ea, eb;
    if (rst) begin
      for (int i = 0; i < 256; i++) model[i] = 8'h00;
      exp_out_a = 8'h00;
      exp_out_b = 8'h00;
    end else begin
      if (en_a) exp_out_a = model[in_addr_a];
      if (en_b) exp_out_b = model[in_addr_b];
      if (en_a && we_a) model[in_addr_a] = in_data_a;
      if (en_b && we_b) model[in_addr_b] = in_data_b;
    end
    exp_a_q.push_back(exp_out_a);
    exp_b_q.push_back(exp_out_b);
    @(posedge clk);
    #1;
    ea = exp_a_q.pop_front();
    eb = exp_b_q.pop_front();
    check({tag, "/out_a"}, out_data_a, ea);
    check({tag, "/out_b"}, out_data_b, eb);
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    exp_out_a  = 8'h00;
    exp_out_b  = 8'h00;
    for (int i = 0; i < 256; i++) model[i] = 8'h00;
    rst = 1'b1;
    idle();
    step("reset0");
    step("reset1");
    rst = 1'b0;

    // Fill 0..3 with 0x05; first write lands on the first edge after reset.
    for (int i = 0; i < 4; i++) begin
      set_a(1'b1, 1'b1, 8'(i), 8'h05);
      step("fill");
    end
    idle();
    set_a(1'b1, 1'b0, 8'h03, 8'h00);
    step("fill_rd");
    check("fill_mem3", dut.memory[3], 8'h05);

    // Reset with an in-flight write: write discarded, all cleared.
    rst = 1'b1;
    set_a(1'b1, 1'b1, 8'h00, 8'h55);
    step("rst_mid");
    rst = 1'b0;
    idle();
    for (int i = 0; i < 4; i++) begin
      set_b(1'b1, 1'b0, 8'(i), 8'h00);
      step("rst_clear_rd");
    end
    check("rst_mem0", dut.memory[0], 8'h00);

    // A writes, B reads back one cycle later.
    idle();
    set_a(1'b1, 1'b1, 8'h10, 8'hA5);
    step("wr_a10");
    idle();
    set_b(1'b1, 1'b0, 8'h10, 8'h00);
    step("rd_b10");
    check("rd_b10_const", out_data_b, 8'hA5);

    // Read-modify-write on port A at 0x02, three read/write rounds.
    idle();
    for (int r = 0; r < 3; r++) begin
      set_a(1'b1, 1'b0, 8'h02, 8'h00);
      step("rmw_rd");
      set_a(1'b1, 1'b1, 8'h02, out_data_a + 8'h01);
      step("rmw_wr");
    end
    check("rmw_mem2", dut.memory[2], 8'h03);

    // Cross-port read during write returns old data.
    set_a(1'b1, 1'b1, 8'h20, 8'h7E);
    set_b(1'b1, 1'b0, 8'h20, 8'h00);
    step("xport_same");
    check("xport_old", out_data_b, 8'h00);
    idle();
    set_b(1'b1, 1'b0, 8'h20, 8'h00);
    step("xport_next");
    check("xport_new", out_data_b, 8'h7E);

    // Dual write collision: port B's data stored.
    set_a(1'b1, 1'b1, 8'h30, 8'h11);
    set_b(1'b1, 1'b1, 8'h30, 8'h22);
    step("collide");
    check("collide_mem", dut.memory[8'h30], 8'h22);

    // we_a without en_a is ignored and out_data_a holds.
    idle();
    set_a(1'b1, 1'b0, 8'h10, 8'h00);
    step("hold_pre");
    set_a(1'b0, 1'b1, 8'h40, 8'h99);
    step("hold_dis");
    check("hold_out_a", out_data_a, 8'hA5);
    check("hold_mem40", dut.memory[8'h40], 8'h00);

    // Top address boundary on both ports.
    idle();
    set_b(1'b1, 1'b1, 8'hFF, 8'h3C);
    step("top_wr");
    idle();
    set_a(1'b1, 1'b0, 8'hFF, 8'h00);
    step("top_rd");
    check("top_rd_const", out_data_a, 8'h3C);

    // Random traffic over a narrow address window to force overlaps.
    for (int n = 0; n < 60; n++) begin
      set_a(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            8'($urandom_range(240, 255)), 8'($urandom_range(0, 255)));
      set_b(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            8'($urandom_range(240, 255)), 8'($urandom_range(0, 255)));
      step("rand");
    end
    for (int i = 240; i < 256; i++) begin
      check("rand_mem", dut.memory[i], model[i]);
    end

    // Final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mem.md
MEM -- requirements
Module: mem

Interface
REQ-001 Parameter DATA_WIDTH, default 8, SHALL set the word width in bits.
REQ-002 Parameter ADDR_WIDTH, default 8, SHALL set the address width; depth SHALL be 2**ADDR_WIDTH words.
REQ-003 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 rst  input  1  SHALL be the synchronous, active-high reset.
REQ-005 in_data_a  input  DATA_WIDTH  SHALL carry port A write data.
REQ-006 in_addr_a  input  ADDR_WIDTH  SHALL carry the port A address.
REQ-007 en_a  input  1  SHALL enable port A access.
REQ-008 we_a  input  1  SHALL select a port A write when en_a is high.
REQ-009 out_data_a  output  DATA_WIDTH  SHALL carry port A read data.
REQ-010 in_data_b, in_addr_b, en_b, we_b, out_data_b SHALL mirror REQ-005..REQ-009 for port B.
REQ-011 Storage SHALL be an array named memory, indexed 0..2**ADDR_WIDTH-1, readable by hierarchical reference from a bench.

Function
REQ-012 Each port SHALL be fully independent, true dual-port, same clock.
REQ-013 Read: when en_x=1 at a rising edge, out_data_x SHALL load memory[in_addr_x]; read latency is exactly 1 cycle.
REQ-014 Write: when en_x=1 and we_x=1 at a rising edge, memory[in_addr_x] SHALL load in_data_x.
REQ-015 A write cycle SHALL also update out_data_x with the old contents (read-first).
REQ-016 When en_x=0, that port SHALL neither read nor write, and out_data_x SHALL hold its value.
REQ-017 we_x with en_x=0 SHALL be ignored.
REQ-018 A read on one port of an address written by the other port in the same cycle SHALL return the old data.
REQ-019 Both ports writing the same address in the same cycle: port B data SHALL be stored.
REQ-020 Read-modify-write by a client (read cycle N, write out_data_x+1 in cycle N+1) SHALL work back to back with no stall.
REQ-021 Addresses SHALL use the full ADDR_WIDTH range with no wrap or bounds logic.

Reset
REQ-022 While rst=1 at a rising edge, every memory word SHALL be cleared to 0.
REQ-023 While rst=1, out_data_a and out_data_b SHALL be cleared to 0.
REQ-024 Reset SHALL take priority over any read or write in the same cycle.
REQ-025 The first access SHALL be accepted on the first edge with rst=0.
REQ-026 Reset asserted mid-operation SHALL discard the in-flight access and clear all contents.

Configuration
REQ-027 Macro MEM_COLLISION_CHECK_EN, when defined, SHALL make simulation report an error with both addresses and the time whenever both ports write the same address in the same cycle.
REQ-028 Without MEM_COLLISION_CHECK_EN, no check logic SHALL exist, and behaviour SHALL follow REQ-019 silently.

Verification
REQ-029 Reset clear: fill addresses 0..3 with 0x05, pulse rst, then read 0..3 on port B -> each read returns 0x00 one cycle later.
REQ-030 Port A write 0xA5 to 0x10, then read 0x10 on port B -> out_data_b = 0xA5 after 1 cycle.
REQ-031 Read-modify-write on port A: read 0x02 (0x00), then write out_data_a+1 three times -> memory[2] = 0x03.
REQ-032 Port A writes 0x7E to 0x20 while port B reads 0x20 in the same cycle -> out_data_b shows the old 0x00; the next read returns 0x7E.
REQ-033 Both ports write 0x30 (A=0x11, B=0x22) -> memory[0x30] = 0x22, and an error is reported only when MEM_COLLISION_CHECK_EN is defined.
REQ-034 en_a=0 with we_a=1 to 0x40 -> memory[0x40] is unchanged and out_data_a holds its prior value.
